led_serial_rx: RTL

Serial-to-parallel receiver for the LED board path: the receiving end of the loadable, tick-paced, MSB-first shift-out link used to drive LED banks. It sits behind the clock divider, samples one bit per divider tick after a `load` frame marker, checks a stop bit, and updates a registered `led` bus only on a good frame. It lets one board's LED pattern be forwarded serially to another.

---
 rtl/led_serial_rx_if.sv | 23 ++
 rtl/led_serial_rx.sv | 97 +++++++++
 2 files changed

// File: rtl/led_serial_rx_if.sv
// Bus bundle for the LED serial receiver.
// Carries the tick-paced serial inputs and the received word/status outputs.
interface led_serial_rx_if #(
   parameter int WIDTH = 8
);
   logic             tick;
   logic             load;
   logic             sin;
   logic [WIDTH-1:0] led;
   logic             valid;
   logic             frame_err;
   logic             busy;

   modport master (
      output tick, load, sin,
      input  led, valid, frame_err, busy
   );

   modport slave (
      input  tick, load, sin,
      output led, valid, frame_err, busy
   );
endinterface

// File: rtl/led_serial_rx.sv
// Serial-to-parallel LED link receiver.
// Marker tick, WIDTH data bits MSB first, then a stop bit; led updates on good frames.
module led_serial_rx #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   led_serial_rx_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] led_n;
   logic             valid_n;
   logic             err_n;

   // State, counter, shift register and all outputs advance together
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         shreg         <= '0;
         bus.led       <= '0;
         bus.valid     <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         shreg         <= shreg_n;
         bus.led       <= led_n;
         bus.valid     <= valid_n;
         bus.frame_err <= err_n;
         bus.busy      <= (state_n != IDLE);
      end
   end

   // Next-state and datapath; nothing moves without tick, load beats sampling
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      led_n   = bus.led;
      valid_n = 1'b0;
      err_n   = 1'b0;
      if (bus.tick) begin
         unique case (state)
            IDLE: begin
               if (bus.load) begin
                  state_n = DATA;
                  cnt_n   = '0;
               end
            end
            DATA: begin
               if (bus.load) begin
                  err_n   = 1'b1;
                  cnt_n   = '0;
                  shreg_n = '0;
               end else begin
                  shreg_n = {shreg[WIDTH-2:0], bus.sin};
                  if (cnt == CW'(WIDTH - 1)) begin
                     state_n = STOP;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (bus.load) begin
                  err_n   = 1'b1;
                  state_n = DATA;
                  cnt_n   = '0;
                  shreg_n = '0;
               end else begin
                  state_n = IDLE;
                  if (bus.sin) begin
                     led_n   = shreg;
                     valid_n = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule
